// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the synchronous instruction memory.
// The optional parity build is selected with IMEM_PARITY_EN (see imem_sync.sv).
package imem_pkg;

  // Sequencer states: CLEAR zero-fills the array after reset, RUN serves traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } imem_state_e;

  // Default geometry of the LEGv8 instruction store.
  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_DATA_W = 32;

  // The word written by the clear sequencer. An all-zero word is what an
  // unloaded slot reads back as; the core treats it as a no-op fetch.
  localparam logic [IMEM_DATA_W-1:0] IMEM_NOP = '0;

  // Even parity over a data word: the stored bit makes the total count of
  // ones (data plus parity) even.
  function automatic logic even_parity(input logic [IMEM_DATA_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_array.sv
// imem_array: storage for imem_sync. One synchronous write port and one
// synchronous read-first read port. Width is chosen by the parent
// (DATA_W, or DATA_W+1 when IMEM_PARITY_EN carries a parity bit).
module imem_array #(
  parameter int ADDR_W = 6,
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  // Index width sized to the implemented depth; callers only present
  // in-range addresses, so truncation never aliases.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] ridx;

  assign widx = IDX_W'(waddr);
  assign ridx = IDX_W'(raddr);

  // Write port: array contents are not reset; the parent's clear sequencer
  // zero-fills them after every reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Read port: the nonblocking read samples the pre-write contents, so a
  // same-cycle write to the same word returns the old value (read-first).
  // The output register only updates on a read and resets to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[ridx];
    end
  end

endmodule

// File: rtl/imem_sync.sv
// imem_sync: registered-read instruction memory with a valid/ready fetch
// port, an unthrottled load port and a post-reset zero-clear sequencer.
// Build option: define IMEM_PARITY_EN to store an even-parity bit per word
// and report mismatches on rsp_perr; otherwise rsp_perr is tied low.
module imem_sync
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_perr,
  input  logic              load_en,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  // Handshake rules: a fetch transfers on a rising edge where req_valid and
  // req_ready are both high; a response transfers on a rising edge where
  // rsp_valid and rsp_ready are both high. Once raised, rsp_valid stays high
  // and rsp_data/rsp_err/rsp_perr stay stable until the response transfers.
  // req_ready never depends on req_valid, so there is no combinational loop.

  // One extra bit so the counter can hold DEPTH even when DEPTH = 2**ADDR_W.
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  imem_state_e      state;
  logic [CNT_W-1:0] clr_cnt;
  logic             clr_last;
  logic             clearing;

  logic             req_in_range;
  logic             load_in_range;
  logic             accept;

  logic             arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [MEM_W-1:0] arr_wdata;
  logic             arr_re;
  logic [MEM_W-1:0] arr_rdata;

  assign clearing = (state == CLEAR);
  assign clr_last = (clr_cnt == CNT_W'(DEPTH - 1));

  assign req_in_range  = ({1'b0, req_addr}  < DEPTH_X);
  assign load_in_range = ({1'b0, load_addr} < DEPTH_X);

  // Single-entry output register: take a new fetch whenever the slot is
  // empty or is being drained this cycle.
  assign req_ready = load_ready && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  // Out-of-range fetches never touch the array.
  assign arr_re = accept && req_in_range;

  // Write port mux: clear sequencer owns the array in CLEAR, loads in RUN.
  // Out-of-range loads are dropped here.
  assign arr_we    = clearing || (load_ready && load_en && load_in_range);
  assign arr_waddr = clearing ? ADDR_W'(clr_cnt) : load_addr;

`ifdef IMEM_PARITY_EN
  assign arr_wdata = clearing ? {1'b0, DATA_W'(IMEM_NOP)}
                              : {^load_data, load_data};
`else
  assign arr_wdata = clearing ? DATA_W'(IMEM_NOP) : load_data;
`endif

  imem_array #(
    .ADDR_W (ADDR_W),
    .WIDTH  (MEM_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (arr_we),
    .waddr   (arr_waddr),
    .wdata   (arr_wdata),
    .re      (arr_re),
    .raddr   (req_addr),
    .rdata   (arr_rdata)
  );

  // Clear/run sequencer plus the response-valid and error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      load_ready <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_last) begin
            state      <= RUN;
            load_ready <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            rsp_valid <= 1'b1;
            rsp_err   <= !req_in_range;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state      <= CLEAR;
          clr_cnt    <= '0;
          load_ready <= 1'b0;
        end
      endcase
    end
  end

  // Response word: the array read register holds the fetched word; an
  // out-of-range fetch leaves it untouched and is masked to zero here.
  assign rsp_data = rsp_err ? '0 : arr_rdata[DATA_W-1:0];

`ifdef IMEM_PARITY_EN
  // Parity check on the registered word; silent for out-of-range fetches.
  assign rsp_perr = !rsp_err && (arr_rdata[DATA_W] ^ (^arr_rdata[DATA_W-1:0]));
`else
  assign rsp_perr = 1'b0;
`endif

endmodule

// File: tb/tb_imem_sync.sv
// tb_imem_sync: table-driven bench with an expected-response queue for imem_sync.
module tb_imem_sync;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 48;
  localparam int EXP_W  = DATA_W + 2;

  logic              clk;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              rsp_perr;
  logic              load_en;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  imem_sync #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .rsp_perr   (rsp_perr),
    .load_en    (load_en),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d, required < 20000)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  int last_rsp_cyc = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  function automatic logic [EXP_W-1:0] mk(input logic [DATA_W-1:0] d, input logic e, input logic p);
    return {p, e, d};
  endfunction

  // Compare every response as it is consumed (sampled mid-cycle).
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got %h, required no response", {rsp_perr, rsp_err, rsp_data});
      end else begin
        e = exp_q.pop_front();
        check("rsp", 64'({rsp_perr, rsp_err, rsp_data}), 64'(e));
      end
      last_rsp_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fetch(input logic [ADDR_W-1:0] a, input logic [EXP_W-1:0] e);
    int n;
    n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL fetch_timeout: addr %0d not accepted after %0d cycles, required acceptance", a, n);
    end else begin
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
  endtask

  task automatic load_off();
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Called right after reset_n rises between edges; counts edges until ready.
  task automatic measure_clear(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 200) begin
      k++;
      @(negedge clk);
    end
    load_en = 1'b0;
    check(tag, 64'(k), 64'(DEPTH));
    check({tag, "_load_ready"}, 64'(load_ready), 64'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  64'(req_ready),  64'(0));
    check({tag, "_rsp_valid"},  64'(rsp_valid),  64'(0));
    check({tag, "_rsp_data"},   64'(rsp_data),   64'(0));
    check({tag, "_rsp_err"},    64'(rsp_err),    64'(0));
    check({tag, "_rsp_perr"},   64'(rsp_perr),   64'(0));
    check({tag, "_load_ready"}, 64'(load_ready), 64'(0));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              err;
  } vec_t;

  logic [DATA_W-1:0] prog [19] = '{
    32'hf8000000, 32'hf8008001, 32'hf8010002, 32'hf8018003, 32'hf8020004,
    32'hf8028005, 32'hf8030006, 32'hf8400007, 32'hf8408008, 32'hf8410009,
    32'hf841800a, 32'hf842000b, 32'hf842800c, 32'hf843000d, 32'hcb0e01ce,
    32'hb400004e, 32'hcb01000f, 32'h8b01000f, 32'hf803800f
  };

  vec_t vecs [25];

  // ---------------- test ----------------
  initial begin
    int c0;
    logic [DATA_W-1:0] w;

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;

    for (int i = 0; i < 25; i++) begin
      vecs[i].addr = ADDR_W'(i);
      vecs[i].data = (i < 19) ? prog[i] : '0;
      vecs[i].err  = 1'b0;
    end

    // Reset values and clear duration.
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_held");
    @(posedge clk); #2;
    reset_n = 1'b1;
    measure_clear("clear_len");

    // Program load, then back-to-back fetch of 0..24.
    for (int i = 0; i < 19; i++) load(ADDR_W'(i), prog[i]);
    load_off();
    c0 = 0;
    for (int i = 0; i < 25; i++) begin
      fetch(vecs[i].addr, mk(vecs[i].data, vecs[i].err, 1'b0));
      if (i == 0) c0 = cyc;
    end
    idle();
    drain();
    check("burst_last_cycle", 64'(last_rsp_cyc), 64'(c0 + 25));
    @(negedge clk);
    check("idle_no_valid", 64'(rsp_valid), 64'(0));

    // Back-pressure: response for addr 7 held for 3 cycles.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    fetch(6'd7, mk(prog[7], 1'b0, 1'b0));
    @(posedge clk); #1;
    req_addr = 6'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid",     64'(rsp_valid), 64'(1));
      check("hold_data",      64'(rsp_data),  64'(prog[7]));
      check("hold_req_ready", 64'(req_ready), 64'(0));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("hold_release_ready", 64'(req_ready), 64'(1));
    exp_q.push_back(mk(prog[8], 1'b0, 1'b0));
    idle();
    drain();

    // Range handling.
    fetch(6'd50, mk('0, 1'b1, 1'b0));
    idle();
    drain();
    load(6'd50, 32'h5555aaaa);
    load_off();
    fetch(6'd50, mk('0, 1'b1, 1'b0));
    fetch(6'd2,  mk(prog[2], 1'b0, 1'b0));
    fetch(6'd47, mk('0, 1'b0, 1'b0));
    fetch(6'd18, mk(prog[18], 1'b0, 1'b0));
    idle();
    drain();

    // Read-first: load and fetch addr 3 in the same cycle.
    @(posedge clk); #1;
    load_en   = 1'b1;
    load_addr = 6'd3;
    load_data = 32'hdeadbeef;
    req_valid = 1'b1;
    req_addr  = 6'd3;
    @(negedge clk);
    check("rf_req_ready", 64'(req_ready), 64'(1));
    exp_q.push_back(mk(prog[3], 1'b0, 1'b0));
    @(posedge clk); #1;
    load_en = 1'b0;
    @(negedge clk);
    check("rf_req_ready2", 64'(req_ready), 64'(1));
    exp_q.push_back(mk(32'hdeadbeef, 1'b0, 1'b0));
    idle();
    drain();

    // A few random in-range fetches of loaded words.
    for (int i = 0; i < 6; i++) begin
      int a;
      a = $urandom_range(4, 18);
      fetch(ADDR_W'(a), mk(prog[a], 1'b0, 1'b0));
    end
    idle();
    drain();

`ifdef IMEM_PARITY_EN
    // Corrupt one stored data bit of addr 2 behind the parity bit's back.
    @(posedge clk); #1;
    dut.u_array.mem[2][0] = ~dut.u_array.mem[2][0];
    w = prog[2] ^ 32'h1;
    fetch(6'd2, mk(w, 1'b0, 1'b1));
    fetch(6'd1, mk(prog[1], 1'b0, 1'b0));
    idle();
    drain();
`endif

    // Reset mid-stream: outputs drop at once, clear restarts, contents lost.
    fetch(6'd4, mk(prog[4], 1'b0, 1'b0));
    @(posedge clk); #1;
    check("pre_reset_valid", 64'(rsp_valid), 64'(1));
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    req_valid = 1'b0;
    load_en   = 1'b1;
    load_addr = 6'd5;
    load_data = 32'h12345678;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    measure_clear("clear_len_mid");
    w = '0;
    fetch(6'd0, mk(w, 1'b0, 1'b0));
    fetch(6'd3, mk(w, 1'b0, 1'b0));
    fetch(6'd5, mk(w, 1'b0, 1'b0));
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_sync.md
# imem_sync

Parametrised, synchronous instruction memory for the single-cycle LEGv8 core and its pipelined follow-on. Replaces the fixed 64×32 combinational ROM with a registered-read array that has a valid/ready fetch port, a write port for program loading, and a post-reset zero-clear sequencer. Out-of-range fetches are flagged. Words that are never loaded read back as 0.

## Interface
Parameters:
- ADDR_W, 6: fetch/load address width (word addressed)
- DATA_W, 32: instruction width
- DEPTH, 64: implemented words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_W

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request valid
- req_ready  out  1  fetch request accepted when high with req_valid
- req_addr  in  ADDR_W  fetch word address
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DATA_W  fetched instruction
- rsp_err  out  1  fetch address ≥ DEPTH
- rsp_perr  out  1  parity mismatch on fetched word (see Configuration)
- load_en  in  1  write strobe, honoured only when load_ready=1
- load_ready  out  1  array writable
- load_addr  in  ADDR_W  load word address
- load_data  in  DATA_W  load word

## Operation
- FSM states are CLEAR and RUN. reset_n low forces CLEAR with clr_cnt=0.
- CLEAR:
  - writes 0 to word clr_cnt each cycle and increments clr_cnt.
  - After the write to word DEPTH-1, the next state is RUN.
  - req_ready=0 and load_ready=0; load_en is ignored.
- RUN:
  - load_ready=1.
  - req_ready = !rsp_valid || rsp_ready, giving a single-entry output register that streams at 1 fetch/cycle.
- Fetch accept (req_valid && req_ready):
  - Next cycle: rsp_valid=1 and rsp_data = mem[req_addr].
  - If req_addr ≥ DEPTH: rsp_data=0, rsp_err=1, and the array is not accessed.
- Response hold: rsp_valid && !rsp_ready holds rsp_data, rsp_err and rsp_perr stable.
- rsp_valid clears when the response is accepted and no new request is accepted in the same cycle.
- Load in RUN with load_en=1:
  - In range: writes mem[load_addr] = load_data.
  - load_addr ≥ DEPTH: the write is dropped silently.
- Load and fetch to the same address in the same cycle: the fetch returns the old word (read-first). The new word is visible to fetches accepted from the next cycle on.
- Loads are independent of the fetch handshake and are never back-pressured in RUN.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_perr=0, load_ready=0.
  - state=CLEAR, clr_cnt=0.
- Clear duration: exactly DEPTH cycles after the first clk edge with reset_n high. req_ready and load_ready rise together on cycle DEPTH.
- Fetch latency: 1 cycle (accept edge N → rsp_valid visible after edge N, consumable at edge N+1).
- Throughput: 1 fetch/cycle while rsp_ready=1.
- Reset mid-operation:
  - In-flight response is discarded, and all outputs return to reset values asynchronously.
  - Clear restarts from word 0, and previously loaded contents are lost.
- clr_cnt width is $clog2(DEPTH)+1 to avoid wrap when DEPTH = 2**ADDR_W.

## Configuration
- IMEM_PARITY_EN defined:
  - Each stored word carries one extra even-parity bit, computed on every write (clear writes parity 0).
  - On fetch, rsp_perr = stored parity XOR ^data, registered alongside rsp_data.
  - rsp_perr is 0 for out-of-range fetches.
- Not defined: the array is DATA_W wide and rsp_perr is tied 0. The port list is identical in both builds.

## Structure
- imem_pkg holds:
  - the state enum (CLEAR, RUN)
  - default widths IMEM_ADDR_W=6 and IMEM_DATA_W=32
  - the LEGv8 NOP/zero-word constant
- Sub-module imem_array is the storage, with one synchronous write port and one synchronous read-first read port. Its width is DATA_W or DATA_W+1 depending on IMEM_PARITY_EN.
- imem_sync holds the FSM, clear counter, handshake and range checking.

## Test plan
- Reset, then load words 0..18 = f8000000, f8008001, f8010002, f8018003, f8020004, f8028005, f8030006, f8400007, f8408008, f8410009, f841800a, f842000b, f842800c, f843000d, cb0e01ce, b400004e, cb01000f, 8b01000f, f803800f. Back-to-back fetch of 0..24 → matching words, then 0 for 19..24; 25 responses in 25 consecutive cycles.
- Hold rsp_ready=0 for 3 cycles after fetching addr 7 → rsp_data=f8400007 stable and req_ready=0 throughout. Next response is addr 8 = f8408008 with no loss or duplicate.
- DEPTH=48, fetch addr 50 → rsp_data=0, rsp_err=1. Load to addr 50 → mem unchanged. Fetch addr 47 → rsp_err=0.
- Same cycle: load addr 3 = deadbeef and fetch addr 3 → old f8018003. Next fetch of addr 3 → deadbeef.
- Assert reset_n low mid-stream after loading → outputs zero immediately. req_ready stays 0 for exactly DEPTH cycles. Fetch addr 0 then returns 0.
- IMEM_PARITY_EN: force one stored data bit of addr 2 → fetch of addr 2 gives rsp_perr=1. Fetch of addr 1 gives rsp_perr=0.
